avmm_rr_arbiter2: RTL and testbench
===================================

Name: avmm_rr_arbiter2

Overview:
Two-master to one-slave Avalon-MM arbiter. It lets the rv32i core's instruction bus (master 0) and data bus (master 1) share a single pipelined slave, such as on-chip RAM or the peripheral fabric holding LEDs, switches and the debug character port at 0x1000000. It arbitrates round-robin, holds the grant through slave stalls, and tracks outstanding reads so that returned read data reaches the master that issued the read.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; byteenable is DATA_W/8 bits
MAX_PEND, 4, maximum outstanding reads; depth of the read-ID FIFO (power of 2, at least 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
mN_address  in  ADDR_W  master N address (N = 0, 1; applies to every mN_ line)
mN_read  in  1  master N read request
mN_write  in  1  master N write request
mN_writedata  in  DATA_W  master N write data
mN_byteenable  in  DATA_W/8  master N byte enables
mN_waitrequest  out  1  stall to master N
mN_readdata  out  DATA_W  read data to master N
mN_readdatavalid  out  1  read data valid to master N
s_address  out  ADDR_W  slave address
s_read  out  1  slave read
s_write  out  1  slave write
s_writedata  out  DATA_W  slave write data
s_byteenable  out  DATA_W/8  slave byte enables
s_waitrequest  in  1  slave stall
s_readdata  in  DATA_W  slave read data
s_readdatavalid  in  1  slave read data valid
err_unexp_rdv  out  1  sticky flag: s_readdatavalid arrived with no read outstanding

Behaviour:
- Request: reqN = mN_read | mN_write. A master asserting both read and write at once is a protocol violation; the read takes precedence.
- Selection, combinational, zero added latency:
  - If lock=1, the selected master is owner.
  - Otherwise, if only one master requests, that master is selected.
  - Otherwise, when both request, the selected master is prio.
- The selected master's address, writedata, byteenable and read/write drive the s_* lines. When no master is selected, s_read=s_write=0 and the data lines are don't-care.
- Read blocking: a selected read while pend_cnt==MAX_PEND and s_readdatavalid=0 is not presented: s_read=0 and the master sees waitrequest=1. A pop in the same cycle frees a slot, so the read may issue.
- Accept condition: (s_read|s_write) & !s_waitrequest.
- mN_waitrequest = !(N selected & accept). The unselected master always sees waitrequest=1.
- Lock: set to 1, with owner = selected master, when a request is presented and s_waitrequest=1. Cleared on accept. The grant never switches while a presented transfer is stalled.
- Round-robin: on accept, prio flips to the other master. Unaccepted cycles do not change prio.
- Read-ID FIFO:
  - An accepted read pushes the master ID.
  - s_readdatavalid pops the head ID.
  - mH_readdatavalid = s_readdatavalid & (head==H); the other master's readdatavalid stays 0.
  - Both mN_readdata outputs carry s_readdata.
  - Push and pop in the same cycle leave pend_cnt unchanged and are legal when full.
- Writes are posted and never touch the FIFO.
- Unexpected readdatavalid: s_readdatavalid with pend_cnt==0 produces no master readdatavalid and sets err_unexp_rdv=1. The flag stays set until rst.
- Reset, synchronous:
  - State: pend_cnt=0, FIFO pointers=0, lock=0, owner=0, prio=0, err_unexp_rdv=0.
  - Outputs while rst=1: s_read=s_write=0, mN_waitrequest=1, mN_readdatavalid=0.
  - Reset mid-operation discards all outstanding read IDs. The slave shares rst.
- Wrap: FIFO pointers are log2(MAX_PEND) bits and wrap modulo MAX_PEND. pend_cnt is log2(MAX_PEND)+1 bits.

Decomposition:
- Package avmm_arb_pkg holds the master-ID type (1 bit), the M_IB=0 and M_DB=1 constants, and the pend_cnt width function.
- Sub-module avmm_id_fifo: a synchronous FIFO of width 1 and depth MAX_PEND, with push, pop, head, full and empty. It is instantiated once.

Test Plan:
- Only m1 writes 0xAB to 0x1000000, slave waitrequest=0 → s_write for 1 cycle with s_address=0x1000000, m1_waitrequest=0 that cycle, m0_waitrequest=1, prio becomes 0.
- Both masters issue a read every cycle with the slave never stalling → grants alternate m0,m1,m0,m1. Slave returns data 1 cycle later and each readdatavalid goes only to the issuing master, in order.
- m0 read presented, slave holds waitrequest=1 for 3 cycles while m1 requests → s_address stays m0's for all 4 cycles. Accepted on cycle 4, then m1 is granted.
- MAX_PEND=4 and the slave withholds readdatavalid → 4 reads are accepted and the 5th sees waitrequest=1 with s_read=0. The 5th is accepted in the same cycle as the first readdatavalid, and pend_cnt stays 4.
- s_readdatavalid pulsed with nothing pending → no mN_readdatavalid and err_unexp_rdv=1, staying 1 until rst.
- rst asserted with 2 reads outstanding → after release pend_cnt=0, prio=0, err_unexp_rdv=0, and the next m0 read is accepted normally.

Source files
------------

// File: rtl/avmm_rr_arbiter2_pkg.sv
// Shared types for the two-master Avalon-MM round-robin arbiter.
//   m_id_t : master identifier (M_IB = instruction bus, M_DB = data bus)
//   cnt_w  : width of a 0..depth occupancy counter
package avmm_arb_pkg;

  typedef enum logic {
    M_IB = 1'b0,
    M_DB = 1'b1
  } m_id_t;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/avmm_rr_arbiter2_if.sv
// Bus bundle for avmm_rr_arbiter2: two Avalon-MM master ports (m0_*, m1_*)
// and one Avalon-MM slave-side port (s_*).
//   modport slave  : arbiter view (accepts master requests, drives the slave)
//   modport master : environment view (drives master requests, models the slave)
interface avmm_rr_arbiter2_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] m0_address;
  logic              m0_read;
  logic              m0_write;
  logic [DATA_W-1:0] m0_writedata;
  logic [BE_W-1:0]   m0_byteenable;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;

  logic [ADDR_W-1:0] m1_address;
  logic              m1_read;
  logic              m1_write;
  logic [DATA_W-1:0] m1_writedata;
  logic [BE_W-1:0]   m1_byteenable;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;

  logic [ADDR_W-1:0] s_address;
  logic              s_read;
  logic              s_write;
  logic [DATA_W-1:0] s_writedata;
  logic [BE_W-1:0]   s_byteenable;
  logic              s_waitrequest;
  logic [DATA_W-1:0] s_readdata;
  logic              s_readdatavalid;

  modport slave (
    input  m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output s_address, s_read, s_write, s_writedata, s_byteenable,
    input  s_waitrequest, s_readdata, s_readdatavalid
  );

  modport master (
    output m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  s_address, s_read, s_write, s_writedata, s_byteenable,
    output s_waitrequest, s_readdata, s_readdatavalid
  );

endinterface

// File: rtl/avmm_rr_arbiter2_id_fifo.sv
// avmm_id_fifo: 1-bit wide synchronous FIFO holding the master ID of each
// outstanding read, in issue order.
//   clk, rst : clock, synchronous active-high reset
//   push,din : enqueue din (ignored when full unless popping the same cycle)
//   pop      : dequeue head (ignored when empty)
//   head     : ID at the front of the queue
//   full,empty
module avmm_id_fifo
  import avmm_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign head  = mem_q[rd_ptr_q];
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);

  always_comb begin
    do_pop   = pop & ~empty;
    // On a full queue the popped slot is the one being written, so
    // push+pop together is safe.
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/avmm_rr_arbiter2.sv
// avmm_rr_arbiter2: two-master to one-slave Avalon-MM round-robin arbiter.
//   clk, rst      : clock, synchronous active-high reset (shared with slave)
//   bus (slave)   : m0_* (instruction bus), m1_* (data bus), s_* (shared slave)
//   err_unexp_rdv : sticky, set when s_readdatavalid arrives with no read pending
// Grant is combinational; it is held through slave stalls and rotates on
// every accepted transfer. Read return routing uses an in-order ID FIFO.
module avmm_rr_arbiter2
  import avmm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_PEND = 4
) (
  input  logic              clk,
  input  logic              rst,
  avmm_rr_arbiter2_if.slave bus,
  output logic              err_unexp_rdv
);
  logic                req0, req1, sel_vld, rd_raw, wr_raw;
  logic                sel_rd, sel_wr, rd_block, s_rd, s_wr, accept;
  m_id_t               sel_id;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W/8-1:0] sel_be;
  logic                fifo_push, fifo_pop, fifo_head, fifo_full, fifo_empty;

  logic  lock_q, lock_d;
  m_id_t owner_q, owner_d;
  m_id_t prio_q, prio_d;
  logic  err_q, err_d;

  always_comb begin
    req0    = bus.m0_read | bus.m0_write;
    req1    = bus.m1_read | bus.m1_write;
    sel_vld = 1'b1;
    sel_id  = M_IB;
    if (lock_q)            sel_id  = owner_q;
    else if (req0 && req1) sel_id  = prio_q;
    else if (req1)         sel_id  = M_DB;
    else if (!req0)        sel_vld = 1'b0;

    if (sel_id == M_DB) begin
      rd_raw    = bus.m1_read;
      wr_raw    = bus.m1_write;
      sel_addr  = bus.m1_address;
      sel_wdata = bus.m1_writedata;
      sel_be    = bus.m1_byteenable;
    end else begin
      rd_raw    = bus.m0_read;
      wr_raw    = bus.m0_write;
      sel_addr  = bus.m0_address;
      sel_wdata = bus.m0_writedata;
      sel_be    = bus.m0_byteenable;
    end

    // Read wins over a simultaneous write from the same master.
    sel_rd   = sel_vld & rd_raw;
    sel_wr   = sel_vld & ~rd_raw & wr_raw;
    // A same-cycle return frees a slot, so a full queue only blocks
    // when nothing is coming back.
    rd_block = sel_rd & fifo_full & ~bus.s_readdatavalid;
    s_rd     = sel_rd & ~rd_block & ~rst;
    s_wr     = sel_wr & ~rst;
    accept   = (s_rd | s_wr) & ~bus.s_waitrequest;

    fifo_push = accept & s_rd;
    fifo_pop  = bus.s_readdatavalid & ~fifo_empty & ~rst;

    lock_d  = lock_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    if (s_rd | s_wr) begin
      if (bus.s_waitrequest) begin
        lock_d  = 1'b1;
        owner_d = sel_id;
      end else begin
        lock_d  = 1'b0;
        prio_d  = (sel_id == M_IB) ? M_DB : M_IB;
      end
    end
    err_d = err_q | (bus.s_readdatavalid & fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q  <= 1'b0;
      owner_q <= M_IB;
      prio_q  <= M_IB;
      err_q   <= 1'b0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      err_q   <= err_d;
    end
  end

  avmm_id_fifo #(
    .DEPTH (MAX_PEND)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (sel_id),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.s_address        = sel_addr;
  assign bus.s_writedata      = sel_wdata;
  assign bus.s_byteenable     = sel_be;
  assign bus.s_read           = s_rd;
  assign bus.s_write          = s_wr;
  assign bus.m0_waitrequest   = ~(accept & (sel_id == M_IB));
  assign bus.m1_waitrequest   = ~(accept & (sel_id == M_DB));
  assign bus.m0_readdata      = bus.s_readdata;
  assign bus.m1_readdata      = bus.s_readdata;
  assign bus.m0_readdatavalid = fifo_pop & (fifo_head == M_IB);
  assign bus.m1_readdatavalid = fifo_pop & (fifo_head == M_DB);
  assign err_unexp_rdv        = err_q;

endmodule

// File: tb/tb_avmm_rr_arbiter2.sv
module tb_avmm_rr_arbiter2;
  localparam int unsigned MAX_PEND = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
  int   errors = 0;
  int   checks = 0;

  avmm_rr_arbiter2_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  avmm_rr_arbiter2 #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_PEND (MAX_PEND)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .err_unexp_rdv (err)
  );

  always #5 clk = ~clk;

  // Reference model: transaction-level state.
  bit q[$];
  bit m_lock, m_owner, m_prio, m_err;
  bit last_acc, last_sel;

  typedef struct {
    bit          s_read, s_write, w0, w1, rdv0, rdv1, acc, sel;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
  } exp_t;

  typedef struct {
    bit rst, r0, wr0, r1, wr1;
    logic [31:0] a0, a1;
    bit sw, rv;
    bit e_rd, e_wr, e_w0, e_w1, e_v0, e_v1, e_err, chk_a;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    bit req0, req1, have, rd, wr;
    e = '{default: '0};
    e.w0 = 1'b1;
    e.w1 = 1'b1;
    if (rst) return e;
    req0 = bus.m0_read | bus.m0_write;
    req1 = bus.m1_read | bus.m1_write;
    have = 1'b1;
    if (m_lock)            e.sel = m_owner;
    else if (req0 && req1) e.sel = m_prio;
    else if (req0)         e.sel = 1'b0;
    else if (req1)         e.sel = 1'b1;
    else                   have  = 1'b0;
    if (have) begin
      rd = e.sel ? bus.m1_read : bus.m0_read;
      wr = !rd && (e.sel ? bus.m1_write : bus.m0_write);
      if (rd && q.size() == MAX_PEND && !bus.s_readdatavalid) rd = 1'b0;
      e.s_read  = rd;
      e.s_write = wr;
      e.addr    = e.sel ? bus.m1_address : bus.m0_address;
      e.wdata   = e.sel ? bus.m1_writedata : bus.m0_writedata;
      e.be      = e.sel ? bus.m1_byteenable : bus.m0_byteenable;
      e.acc     = (rd || wr) && !bus.s_waitrequest;
      if (e.acc) begin
        if (e.sel) e.w1 = 1'b0;
        else       e.w0 = 1'b0;
      end
    end
    if (bus.s_readdatavalid && q.size() > 0) begin
      if (q[0]) e.rdv1 = 1'b1;
      else      e.rdv0 = 1'b1;
    end
    return e;
  endfunction

  function automatic void commit(input exp_t e);
    if (rst) begin
      q.delete();
      m_lock = 0; m_owner = 0; m_prio = 0; m_err = 0;
      return;
    end
    if (bus.s_readdatavalid) begin
      if (q.size() > 0) void'(q.pop_front());
      else              m_err = 1'b1;
    end
    if (e.acc && e.s_read) q.push_back(e.sel);
    if (e.s_read || e.s_write) begin
      if (bus.s_waitrequest) begin
        m_lock  = 1'b1;
        m_owner = e.sel;
      end else begin
        m_lock = 1'b0;
        m_prio = !e.sel;
      end
    end
  endfunction

  // Call at the negative edge; returns one cycle later, #1 past posedge.
  task automatic model_step();
    exp_t e;
    e = predict();
    chk("s_read", bus.s_read, e.s_read);
    chk("s_write", bus.s_write, e.s_write);
    chk("m0_waitrequest", bus.m0_waitrequest, e.w0);
    chk("m1_waitrequest", bus.m1_waitrequest, e.w1);
    chk("m0_readdatavalid", bus.m0_readdatavalid, e.rdv0);
    chk("m1_readdatavalid", bus.m1_readdatavalid, e.rdv1);
    chk("err_unexp_rdv", err, m_err);
    if (e.s_read || e.s_write) chk("s_address", bus.s_address, e.addr);
    if (e.s_write) begin
      chk("s_writedata", bus.s_writedata, e.wdata);
      chk("s_byteenable", bus.s_byteenable, e.be);
    end
    if (e.rdv0) chk("m0_readdata", bus.m0_readdata, bus.s_readdata);
    if (e.rdv1) chk("m1_readdata", bus.m1_readdata, bus.s_readdata);
    last_acc = e.acc;
    last_sel = e.sel;
    commit(e);
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
  endtask

  task automatic set_in(input bit r, input bit r0, input bit w0, input bit r1,
                        input bit w1, input bit sw, input bit rv);
    rst                 = r;
    bus.m0_read         = r0;
    bus.m0_write        = w0;
    bus.m1_read         = r1;
    bus.m1_write        = w1;
    bus.s_waitrequest   = sw;
    bus.s_readdatavalid = rv;
    bus.s_readdata      = $urandom;
  endtask

  function automatic vec_t mk(input bit r, input bit r0, input bit w0, input logic [31:0] a0,
                              input bit r1, input bit w1, input logic [31:0] a1,
                              input bit sw, input bit rv,
                              input bit erd, input bit ewr, input bit ew0, input bit ew1,
                              input bit ev0, input bit ev1, input bit eerr,
                              input bit ca, input logic [31:0] ea);
    vec_t v;
    v.rst = r;  v.r0 = r0; v.wr0 = w0; v.a0 = a0; v.r1 = r1; v.wr1 = w1; v.a1 = a1;
    v.sw = sw;  v.rv = rv;
    v.e_rd = erd; v.e_wr = ewr; v.e_w0 = ew0; v.e_w1 = ew1;
    v.e_v0 = ev0; v.e_v1 = ev1; v.e_err = eerr; v.chk_a = ca; v.e_addr = ea;
    return v;
  endfunction

  // Random master agents: a request is held until the model says it was accepted.
  bit          pend0, pend1;

  task automatic new_req(input int m);
    bit rd, wr;
    int k;
    k  = $urandom_range(0, 19);
    rd = (k < 10) || (k == 19);
    wr = (k >= 10);
    if (m == 0) begin
      bus.m0_read = rd; bus.m0_write = wr;
      bus.m0_address = $urandom; bus.m0_writedata = $urandom;
      bus.m0_byteenable = 4'($urandom);
    end else begin
      bus.m1_read = rd; bus.m1_write = wr;
      bus.m1_address = $urandom; bus.m1_writedata = $urandom;
      bus.m1_byteenable = 4'($urandom);
    end
  endtask

  initial begin
    bus.m0_address = '0; bus.m0_writedata = 32'h55; bus.m0_byteenable = 4'hF;
    bus.m1_address = '0; bus.m1_writedata = 32'hAB; bus.m1_byteenable = 4'hF;
    set_in(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    //            rst r0 w0 a0        r1 w1 a1          sw rv  rd wr w0 w1 v0 v1 err ca addr
    vt.push_back(mk(1, 1, 0, 32'h10,  0, 0, 32'h0,      0, 0,  0, 0, 1, 1, 0, 0, 0,  0, 32'h0));
    vt.push_back(mk(0, 0, 0, 32'h0,   0, 1, 32'h1000000,0, 0,  0, 1, 1, 0, 0, 0, 0,  1, 32'h1000000));
    vt.push_back(mk(0, 1, 0, 32'h10,  1, 0, 32'h20,     0, 0,  1, 0, 0, 1, 0, 0, 0,  1, 32'h10));
    vt.push_back(mk(0, 1, 0, 32'h10,  1, 0, 32'h20,     0, 1,  1, 0, 1, 0, 1, 0, 0,  1, 32'h20));
    vt.push_back(mk(0, 1, 0, 32'h10,  1, 0, 32'h20,     0, 1,  1, 0, 0, 1, 0, 1, 0,  1, 32'h10));
    vt.push_back(mk(0, 0, 0, 32'h0,   0, 0, 32'h0,      0, 1,  0, 0, 1, 1, 1, 0, 0,  0, 32'h0));
    vt.push_back(mk(0, 1, 0, 32'h30,  0, 0, 32'h40,     1, 0,  1, 0, 1, 1, 0, 0, 0,  1, 32'h30));
    vt.push_back(mk(0, 1, 0, 32'h30,  1, 0, 32'h40,     1, 0,  1, 0, 1, 1, 0, 0, 0,  1, 32'h30));
    vt.push_back(mk(0, 1, 0, 32'h30,  1, 0, 32'h40,     1, 0,  1, 0, 1, 1, 0, 0, 0,  1, 32'h30));
    vt.push_back(mk(0, 1, 0, 32'h30,  1, 0, 32'h40,     0, 0,  1, 0, 0, 1, 0, 0, 0,  1, 32'h30));
    vt.push_back(mk(0, 1, 0, 32'h30,  1, 0, 32'h40,     0, 0,  1, 0, 1, 0, 0, 0, 0,  1, 32'h40));
    vt.push_back(mk(0, 0, 0, 32'h0,   0, 0, 32'h0,      0, 1,  0, 0, 1, 1, 1, 0, 0,  0, 32'h0));
    vt.push_back(mk(0, 0, 0, 32'h0,   0, 0, 32'h0,      0, 1,  0, 0, 1, 1, 0, 1, 0,  0, 32'h0));
    vt.push_back(mk(0, 0, 0, 32'h0,   0, 0, 32'h0,      0, 1,  0, 0, 1, 1, 0, 0, 0,  0, 32'h0));
    vt.push_back(mk(0, 0, 0, 32'h0,   0, 0, 32'h0,      0, 0,  0, 0, 1, 1, 0, 0, 1,  0, 32'h0));

    foreach (vt[i]) begin
      set_in(vt[i].rst, vt[i].r0, vt[i].wr0, vt[i].r1, vt[i].wr1, vt[i].sw, vt[i].rv);
      bus.m0_address = vt[i].a0;
      bus.m1_address = vt[i].a1;
      @(negedge clk);
      chk("tbl_s_read", bus.s_read, vt[i].e_rd);
      chk("tbl_s_write", bus.s_write, vt[i].e_wr);
      chk("tbl_m0_waitrequest", bus.m0_waitrequest, vt[i].e_w0);
      chk("tbl_m1_waitrequest", bus.m1_waitrequest, vt[i].e_w1);
      chk("tbl_m0_readdatavalid", bus.m0_readdatavalid, vt[i].e_v0);
      chk("tbl_m1_readdatavalid", bus.m1_readdatavalid, vt[i].e_v1);
      chk("tbl_err_unexp_rdv", err, vt[i].e_err);
      if (vt[i].chk_a) chk("tbl_s_address", bus.s_address, vt[i].e_addr);
      model_step();
    end

    // Read-ID FIFO full: four reads accepted, fifth blocked until a return.
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 0, 0, 0, 0, 0);
      bus.m0_address = 32'h100 + 32'(i);
      @(negedge clk);
      chk("full_fill_accept", bus.m0_waitrequest, 1'b0);
      model_step();
    end
    set_in(0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("full_block_s_read", bus.s_read, 1'b0);
    chk("full_block_wait", bus.m0_waitrequest, 1'b1);
    model_step();
    set_in(0, 1, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("full_pushpop_s_read", bus.s_read, 1'b1);
    chk("full_pushpop_wait", bus.m0_waitrequest, 1'b0);
    chk("full_pushpop_rdv", bus.m0_readdatavalid, 1'b1);
    model_step();
    set_in(0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("full_still_full", bus.m0_waitrequest, 1'b1);
    model_step();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      chk("full_drain_rdv", bus.m0_readdatavalid, 1'b1);
      model_step();
    end
    set_in(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("unexp_no_rdv", {bus.m0_readdatavalid, bus.m1_readdatavalid}, 2'b00);
    chk("err_still_set", err, 1'b1);
    model_step();

    // Reset with two m1 reads outstanding discards their IDs.
    repeat (2) begin
      set_in(0, 0, 0, 1, 0, 0, 0);
      cycle();
    end
    set_in(1, 0, 0, 0, 0, 0, 0);
    cycle();
    set_in(0, 1, 0, 1, 0, 0, 0);
    bus.m0_address = 32'h200;
    bus.m1_address = 32'h300;
    @(negedge clk);
    chk("rst_err_clear", err, 1'b0);
    chk("rst_prio_m0", bus.s_address, 32'h200);
    chk("rst_m0_accept", bus.m0_waitrequest, 1'b0);
    model_step();
    set_in(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("rst_rdv_m0", bus.m0_readdatavalid, 1'b1);
    chk("rst_no_stale_m1", bus.m1_readdatavalid, 1'b0);
    model_step();

    // Randomized traffic against the model.
    pend0 = 0;
    pend1 = 0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      if (!pend0) begin
        if ($urandom_range(0, 1) == 1) begin new_req(0); pend0 = 1; end
        else begin bus.m0_read = 0; bus.m0_write = 0; end
      end
      if (!pend1) begin
        if ($urandom_range(0, 1) == 1) begin new_req(1); pend1 = 1; end
        else begin bus.m1_read = 0; bus.m1_write = 0; end
      end
      rst                 = ($urandom_range(0, 199) == 0);
      bus.s_waitrequest   = ($urandom_range(0, 9) < 3);
      bus.s_readdatavalid = (q.size() > 0) ? ($urandom_range(0, 9) < 4)
                                           : ($urandom_range(0, 99) < 2);
      bus.s_readdata      = $urandom;
      cycle();
      if (last_acc) begin
        if (last_sel) pend1 = 0;
        else          pend0 = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
